strip_frame_buffer: RTL and testbench
=====================================

# strip_frame_buffer

Double-buffered pixel store that sits directly upstream of the multi-LED strip encoder and drives its flat `strip` vector. Producers write individual pixels or fill the whole strip into a back buffer through valid/ready handshakes. A commit copies the back buffer to the front buffer, which drives `strip`. Commits are rate-limited to one per encoder frame period, so the encoder never sees more than one update per refresh.

## Interface
Parameters:
- LENGTH, 10, number of pixels; must equal the encoder's LENGTH.
- FRAME_CYCLES, (LENGTH+11)*1464, minimum clk cycles between two front-buffer swaps (one full encoder frame including the reset gap).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  pixel write accepted when high with wr_valid.
- wr_addr  in  max(1,$clog2(LENGTH))  pixel index.
- wr_rgb  in  24  colour {R[23:16],G[15:8],B[7:0]}.
- fill_valid  in  1  fill-all request.
- fill_ready  out  1  fill accepted when high with fill_valid.
- fill_rgb  in  24  fill colour, {R,G,B}.
- commit_valid  in  1  swap request.
- commit_ready  out  1  swap accepted when high with commit_valid.
- brightness  in  8  global scale, sampled per written pixel.
- busy  out  1  high while in FILL.
- strip  out  LENGTH*24  front buffer; pixel n at [n*24 +: 24] = {G,R,B}.

## Operation
- States: IDLE, FILL.
- In IDLE, at most one request is accepted per cycle. Priority is commit > fill > write:
  - commit_ready = IDLE && holdoff==0.
  - fill_ready = IDLE && !(commit_valid && commit_ready).
  - wr_ready = IDLE && !fill_valid && !(commit_valid && commit_ready).
- Write: back[wr_addr] <= scale(wr_rgb).
  - wr_addr >= LENGTH is accepted and discarded.
- Fill: latch scale(fill_rgb) at acceptance and go to FILL. An index counter writes back[0..LENGTH-1], one pixel per cycle. Return to IDLE after index LENGTH-1 is written.
- Commit: front <= back, all pixels in one cycle. The back buffer is kept unchanged. holdoff reloads to FRAME_CYCLES-1 and then decrements to 0 (saturating).
- Scale, per channel: c' = (c * (brightness+1)) >> 8, using a 16-bit product.
  - brightness=255 passes the colour through unchanged.
  - brightness=0 maps 255 to 0.
- Reorder: {R,G,B} input is stored as {G,R,B}.
- Reset (asynchronous, any state, including mid-FILL):
  - back and front cleared to 0, so strip=0.
  - state=IDLE, holdoff=0, busy=0.
  - wr_ready, fill_ready and commit_ready are high as soon as rst_n is released (subject to the priority rules above).

## Timing
- A write or fill pixel lands in back on the clock edge of acceptance. It appears on strip only after a later commit.
- strip updates on the clock edge where commit is accepted, and is visible the following cycle.
- Fill takes exactly LENGTH cycles in FILL. busy is high for those LENGTH cycles. fill_ready, wr_ready and commit_ready are low throughout.
- After a commit, commit_ready stays low for FRAME_CYCLES-1 cycles and rises on cycle FRAME_CYCLES.
- A commit held valid while not ready waits. Writes continue to be accepted during the holdoff.
- A commit accepted in the same cycle as wr_valid: the write is not accepted and the swap uses the pre-write back buffer.
- Outputs are registered except the ready signals, which are combinational from state, holdoff and the valids.

## Structure
- Package veo_pkg holds:
  - PIXEL_BITS=24, ENC_SLOT_CYCLES=1464 and ENC_GAP_SLOTS=11.
  - typedef rgb_t as struct {r,g,b} of 8 bits each.
  - typedef fb_state_t as enum {IDLE, FILL}.
- One sub-module, pixel_scaler: a combinational brightness multiply plus the RGB-to-GRB reorder. It is instantiated once and shared by the write and fill paths.

## Test plan
- Reset, then write addr 3 with 0xFF8000 at brightness 255, then commit → strip[3*24+:24]=0x80FF00 and every other pixel 0 one cycle after the commit.
- Fill with 0x102030 at brightness 127 → busy high exactly LENGTH cycles; after commit every pixel reads {G,R,B}=0x100818.
- Commit, then commit_valid held high → commit_ready is low for FRAME_CYCLES-1 cycles and the second swap occurs on cycle FRAME_CYCLES.
- commit_valid, fill_valid and wr_valid all high in IDLE → only the commit is accepted; fill is accepted next cycle; the write waits until fill completes.
- rst_n dropped mid-FILL at index 4 → strip=0, busy=0 and state IDLE immediately; no pixel is written after release.
- Write with addr=LENGTH → wr_ready handshake completes and back is unchanged (verified by a following commit).

Source files
------------

// File: rtl/veo_pkg.sv
// Shared types and encoder timing constants for the strip frame buffer.
package veo_pkg;

  localparam int PIXEL_BITS      = 24;
  localparam int ENC_SLOT_CYCLES = 1464;
  localparam int ENC_GAP_SLOTS   = 11;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fb_state_t;

endpackage

// File: rtl/pixel_scaler.sv
// Combinational global-brightness scale plus {R,G,B} -> {G,R,B} reorder.
module pixel_scaler
  import veo_pkg::*;
(
  input  rgb_t                  rgb,
  input  logic [7:0]            brightness,
  output logic [PIXEL_BITS-1:0] grb
);

  // brightness+1 makes 255 an exact pass-through while 0 still darkens
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  assign grb = {scale(rgb.g, brightness), scale(rgb.r, brightness), scale(rgb.b, brightness)};

endmodule

// File: rtl/strip_frame_buffer.sv
// Double-buffered pixel store feeding the LED strip encoder, with rate-limited commits.
module strip_frame_buffer
  import veo_pkg::*;
#(
  parameter int  LENGTH       = 10,
  parameter int  FRAME_CYCLES = (LENGTH + ENC_GAP_SLOTS) * ENC_SLOT_CYCLES,
  localparam int AW           = (LENGTH > 1) ? $clog2(LENGTH) : 1,
  localparam int HW           = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [AW-1:0]                wr_addr,
  input  logic [23:0]                  wr_rgb,
  input  logic                         fill_valid,
  output logic                         fill_ready,
  input  logic [23:0]                  fill_rgb,
  input  logic                         commit_valid,
  output logic                         commit_ready,
  input  logic [7:0]                   brightness,
  output logic                         busy,
  output fb_state_t                    fsm_state,
  output logic [LENGTH*PIXEL_BITS-1:0] strip
);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // ready never depends on the same channel's valid, and at most one of
  // commit/fill/write fires per cycle (commit > fill > write).

  fb_state_t             state;
  logic [AW-1:0]         fill_idx;
  logic [PIXEL_BITS-1:0] fill_pix;
  logic [HW-1:0]         holdoff;
  logic [PIXEL_BITS-1:0] back  [LENGTH];
  logic [PIXEL_BITS-1:0] front [LENGTH];
  logic [PIXEL_BITS-1:0] scaled;
  logic                  commit_fire, fill_fire, wr_fire;

  always_comb begin
    commit_ready = 1'b0;
    fill_ready   = 1'b0;
    wr_ready     = 1'b0;
    if (state == IDLE) begin
      commit_ready = (holdoff == '0);
      fill_ready   = !(commit_valid && commit_ready);
      wr_ready     = !fill_valid && !(commit_valid && commit_ready);
    end
  end

  assign commit_fire = commit_valid && commit_ready;
  assign fill_fire   = fill_valid && fill_ready;
  assign wr_fire     = wr_valid && wr_ready;

  // Only one of the fill/write paths can be accepted in a cycle, so one scaler serves both
  pixel_scaler u_scaler (
    .rgb        (fill_valid ? rgb_t'(fill_rgb) : rgb_t'(wr_rgb)),
    .brightness (brightness),
    .grb        (scaled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fill_idx <= '0;
      fill_pix <= '0;
      holdoff  <= '0;
      for (int i = 0; i < LENGTH; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
    end else begin
      if (commit_fire) holdoff <= HW'(FRAME_CYCLES - 1);
      else if (holdoff != '0) holdoff <= holdoff - 1'b1;

      case (state)
        IDLE: begin
          if (commit_fire) begin
            for (int i = 0; i < LENGTH; i++) front[i] <= back[i];
          end else if (fill_fire) begin
            fill_pix <= scaled;
            fill_idx <= '0;
            state    <= FILL;
          end else if (wr_fire && (32'(wr_addr) < LENGTH)) begin
            back[wr_addr] <= scaled;
          end
        end
        FILL: begin
          back[fill_idx] <= fill_pix;
          if (fill_idx == AW'(LENGTH - 1)) state <= IDLE;
          else fill_idx <= fill_idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == FILL);
  assign fsm_state = state;

  for (genvar n = 0; n < LENGTH; n++) begin : g_strip
    assign strip[n*PIXEL_BITS +: PIXEL_BITS] = front[n];
  end

endmodule

// File: tb/tb_strip_frame_buffer.sv
// Randomized scoreboard bench for strip_frame_buffer against a pixel-array reference model.
module tb_strip_frame_buffer;
  import veo_pkg::*;

  localparam int L  = 10;
  localparam int F  = 40;
  localparam int AW = 4;
  localparam int SW = L * 24;
  localparam int TO = 2000;

  logic          clk, rst_n;
  logic          wr_valid, wr_ready, fill_valid, fill_ready, commit_valid, commit_ready, busy;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_rgb, fill_rgb;
  logic [7:0]    brightness;
  fb_state_t     fsm_state;
  logic [SW-1:0] strip;

  logic [23:0]   model [L];
  logic [SW-1:0] exp_q [$];
  int            chk_cnt, pass_cnt;
  bit            pending;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  strip_frame_buffer #(.LENGTH(L), .FRAME_CYCLES(F)) dut (
    .clk (clk), .rst_n (rst_n),
    .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_addr (wr_addr), .wr_rgb (wr_rgb),
    .fill_valid (fill_valid), .fill_ready (fill_ready), .fill_rgb (fill_rgb),
    .commit_valid (commit_valid), .commit_ready (commit_ready),
    .brightness (brightness), .busy (busy), .fsm_state (fsm_state), .strip (strip)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [23:0] ref_pixel(input logic [23:0] rgb, input logic [7:0] br);
    int r, g, b, k;
    k = int'(br) + 1;
    r = (int'(rgb[23:16]) * k) / 256;
    g = (int'(rgb[15:8])  * k) / 256;
    b = (int'(rgb[7:0])   * k) / 256;
    return {g[7:0], r[7:0], b[7:0]};
  endfunction

  function automatic logic [SW-1:0] model_flat();
    logic [SW-1:0] v;
    for (int i = 0; i < L; i++) v[i*24 +: 24] = model[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < L; i++) model[i] = '0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out after %0d cycles", name, TO);
  endtask

  // Monitor: a commit seen at one falling edge is checked at the next one
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL strip_unexpected: commit with empty expected queue, strip %h", strip);
        end else begin
          check("strip", strip, exp_q.pop_front());
        end
      end
      pending = commit_valid && commit_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [AW-1:0] addr, input logic [23:0] rgb, input logic [7:0] br);
    int n;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = addr; wr_rgb = rgb; brightness = br;
    for (n = 0; n < TO; n++) begin
      @(negedge clk);
      if (wr_ready) break;
    end
    if (n == TO) timeout("write_handshake");
    @(posedge clk);
    if (int'(addr) < L) model[addr] = ref_pixel(rgb, br);
    #1 wr_valid = 1'b0;
  endtask

  task automatic do_fill(input logic [23:0] rgb, input logic [7:0] br, output int busy_cycles);
    int n;
    busy_cycles = 0;
    @(posedge clk); #1;
    fill_valid = 1'b1; fill_rgb = rgb; brightness = br;
    for (n = 0; n < TO; n++) begin
      @(negedge clk);
      if (fill_ready) break;
    end
    if (n == TO) timeout("fill_handshake");
    @(posedge clk);
    for (int i = 0; i < L; i++) model[i] = ref_pixel(rgb, br);
    #1 fill_valid = 1'b0;
    for (n = 0; n < TO; n++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cycles++;
    end
  endtask

  task automatic do_commit();
    int n;
    @(posedge clk); #1;
    commit_valid = 1'b1;
    for (n = 0; n < TO; n++) begin
      @(negedge clk);
      if (commit_ready) break;
    end
    if (n == TO) timeout("commit_handshake");
    exp_q.push_back(model_flat());
    @(posedge clk); #1;
    commit_valid = 1'b0;
  endtask

  task automatic wait_commit_ready();
    int n;
    for (n = 0; n < TO; n++) begin
      @(negedge clk);
      if (commit_ready) break;
    end
    if (n == TO) timeout("holdoff_expiry");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bc, low, n;
    chk_cnt = 0; pass_cnt = 0;
    rst_n = 1'b0;
    wr_valid = 1'b0; fill_valid = 1'b0; commit_valid = 1'b0;
    wr_addr = '0; wr_rgb = '0; fill_rgb = '0; brightness = '0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("reset_strip", strip, '0);
    check("reset_busy", SW'(busy), '0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_reset", SW'({commit_ready, fill_ready, wr_ready}), SW'(3'b111));

    // Single write, then swap
    do_write(4'd3, 24'hFF8000, 8'd255);
    do_commit();

    // Fill at half brightness
    wait_commit_ready();
    do_fill(24'h102030, 8'd127, bc);
    check("fill_busy_cycles", SW'(bc), SW'(L));
    do_commit();

    // Back-to-back commits: holdoff length
    wait_commit_ready();
    @(posedge clk); #1;
    commit_valid = 1'b1;
    @(negedge clk);
    exp_q.push_back(model_flat());
    low = 0;
    for (n = 0; n < TO; n++) begin
      @(negedge clk);
      if (commit_ready) break;
      low++;
    end
    check("holdoff_low_cycles", SW'(low), SW'(F - 1));
    exp_q.push_back(model_flat());
    @(posedge clk); #1;
    commit_valid = 1'b0;

    // Priority: commit > fill > write
    wait_commit_ready();
    @(posedge clk); #1;
    commit_valid = 1'b1; fill_valid = 1'b1; wr_valid = 1'b1;
    fill_rgb = 24'hA0B0C0; wr_rgb = 24'h123456; wr_addr = 4'd7; brightness = 8'd200;
    @(negedge clk);
    check("prio_commit_only", SW'({commit_ready, fill_ready, wr_ready}), SW'(3'b100));
    exp_q.push_back(model_flat());
    @(posedge clk); #1;
    commit_valid = 1'b0;
    @(negedge clk);
    check("prio_fill_next", SW'({fill_ready, wr_ready}), SW'(2'b10));
    @(posedge clk);
    for (int i = 0; i < L; i++) model[i] = ref_pixel(24'hA0B0C0, 8'd200);
    #1 fill_valid = 1'b0;
    low = 0;
    for (n = 0; n < TO; n++) begin
      @(negedge clk);
      if (wr_ready) break;
      low++;
    end
    check("prio_write_waits", SW'(low), SW'(L));
    @(posedge clk);
    model[7] = ref_pixel(24'h123456, 8'd200);
    #1 wr_valid = 1'b0;
    do_commit();

    // Out-of-range address is accepted and dropped
    do_write(4'd10, 24'hFFFFFF, 8'd255);
    do_write(4'd15, 24'h00FF00, 8'd255);
    do_commit();

    // Randomized mix
    for (int k = 0; k < 60; k++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 7) do_write(AW'($urandom_range(0, 15)), 24'($urandom), 8'($urandom));
      else if (op < 8) begin
        do_fill(24'($urandom), 8'($urandom), bc);
        check("rand_fill_busy", SW'(bc), SW'(L));
      end else do_commit();
    end
    do_commit();

    // Reset in the middle of a fill
    wait_commit_ready();
    @(posedge clk); #1;
    fill_valid = 1'b1; fill_rgb = 24'hFFFFFF; brightness = 8'd255;
    @(negedge clk);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_clear();
    check("midfill_rst_strip", strip, '0);
    check("midfill_rst_busy", SW'(busy), '0);
    check("midfill_rst_state", SW'(fsm_state), SW'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (L + 2) @(negedge clk);
    check("post_rst_ready", SW'({commit_ready, fill_ready, wr_ready, busy}), SW'(4'b1110));
    do_commit();

    // Drain the scoreboard
    for (n = 0; n < TO; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !pending) break;
    end
    if (n == TO) timeout("scoreboard_drain");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
